// File: rtl/sega_joy_pkg.sv
// Shared constants for the DB9 joystick scanner.
//   - STEP_*  : scan sequencer step numbers (the action is taken on the tick
//               that enters the step)
//   - BIT_*   : bit positions inside a 12-bit per-port button word
//               {M,X,Y,Z,S,A,C,B,R,L,D,U}
//   - PIN_*   : bit positions inside a 6-bit per-port pin group
//               {p9,p6,right,left,down,up}
//   - p7_level: select-line level driven while a given step is active
package sega_joy_pkg;

  localparam int STEP_P7LO0  = 0;
  localparam int STEP_P7HI0  = 1;
  localparam int STEP_DIR    = 2;
  localparam int STEP_START  = 3;
  localparam int STEP_P7LO1  = 4;
  localparam int STEP_DET6   = 5;
  localparam int STEP_XYZM   = 6;
  localparam int STEP_P7HI1  = 7;
  localparam int STEP_COMMIT = 8;

  localparam int BIT_U = 0;
  localparam int BIT_D = 1;
  localparam int BIT_L = 2;
  localparam int BIT_R = 3;
  localparam int BIT_B = 4;
  localparam int BIT_C = 5;
  localparam int BIT_A = 6;
  localparam int BIT_S = 7;
  localparam int BIT_Z = 8;
  localparam int BIT_Y = 9;
  localparam int BIT_X = 10;
  localparam int BIT_M = 11;

  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  localparam int JOY_W = 12;
  localparam int PIN_W = 6;

  typedef logic [JOY_W-1:0] joy_word_t;
  typedef logic [PIN_W-1:0] pin_group_t;

  // Select is pulled low four times per frame (steps 0, 2, 4, 6); a
  // 6-button pad counts these falling edges to reach its extra-button state.
  // Everything else, including commit and idle, keeps select high so the
  // long idle gap lets 6-button pads time out and restart their count.
  function automatic logic p7_level(input int step);
    logic lvl;
    lvl = 1'b1;
    case (step)
      STEP_P7LO0, STEP_DIR, STEP_P7LO1, STEP_XYZM: lvl = 1'b0;
      default:                                     lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sega_joy_port.sv
// One DB9 port: decodes the pin group at each scan step into a shadow button
// word plus pad-type flags, and copies the shadow into the output registers
// on commit so the outputs only ever show a completely scanned frame.
//   clk_sys   : system clock
//   reset     : asynchronous, active-high
//   step      : step being entered (valid together with tick)
//   tick      : one-cycle scan step strobe
//   pins      : synchronised active-low pins {p9,p6,right,left,down,up}
//   commit    : one-cycle strobe, publish shadow to outputs
//   joy_state : {M,X,Y,Z,S,A,C,B,R,L,D,U}, 1 = pressed
//   md_pad    : Mega Drive pad seen in last committed frame
//   six_btn   : 6-button pad seen in last committed frame
module sega_joy_port
  import sega_joy_pkg::*;
#(
  parameter int STEP_W     = 8,
  parameter bit SIX_BTN_EN = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [STEP_W-1:0] step,
  input  logic              tick,
  input  pin_group_t        pins,
  input  logic              commit,
  output joy_word_t         joy_state,
  output logic              md_pad,
  output logic              six_btn
);

  joy_word_t sh_state;
  logic      sh_md;
  logic      sh_six;

  // Shadow decode. Each step reads pins that were settled under the select
  // level held for the whole previous step.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sh_state <= '0;
      sh_md    <= 1'b0;
      sh_six   <= 1'b0;
    end else if (tick) begin
      case (int'(step))
        STEP_DIR: begin
          // Select was high: directions plus B on p6, C on p9.
          sh_state[BIT_R] <= ~pins[PIN_RIGHT];
          sh_state[BIT_L] <= ~pins[PIN_LEFT];
          sh_state[BIT_D] <= ~pins[PIN_DOWN];
          sh_state[BIT_U] <= ~pins[PIN_UP];
          sh_state[BIT_C] <= ~pins[PIN_P9];
          sh_state[BIT_B] <= ~pins[PIN_P6];
          sh_md           <= 1'b0;
          sh_six          <= 1'b0;
        end
        STEP_START: begin
          // Select was low: a Mega Drive pad grounds left and right and
          // puts Start on p9, A on p6. A Master System pad holding
          // left+right at once looks identical; that ambiguity is accepted.
          if (!pins[PIN_RIGHT] && !pins[PIN_LEFT]) begin
            sh_md           <= 1'b1;
            sh_state[BIT_S] <= ~pins[PIN_P9];
            sh_state[BIT_A] <= ~pins[PIN_P6];
          end else begin
            sh_state[BIT_S] <= 1'b0;
            sh_state[BIT_A] <= 1'b0;
          end
        end
        STEP_DET6: begin
          // Third low pulse: a 6-button pad grounds all four directions.
          if (SIX_BTN_EN && sh_md && (pins[PIN_RIGHT:PIN_UP] == '0)) begin
            sh_six <= 1'b1;
          end
        end
        STEP_XYZM: begin
          // High after the third low: directions carry Mode, X, Y, Z.
          if (sh_six) begin
            sh_state[BIT_M] <= ~pins[PIN_RIGHT];
            sh_state[BIT_X] <= ~pins[PIN_LEFT];
            sh_state[BIT_Y] <= ~pins[PIN_DOWN];
            sh_state[BIT_Z] <= ~pins[PIN_UP];
          end else begin
            sh_state[BIT_M] <= 1'b0;
            sh_state[BIT_X] <= 1'b0;
            sh_state[BIT_Y] <= 1'b0;
            sh_state[BIT_Z] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_state <= '0;
      md_pad    <= 1'b0;
      six_btn   <= 1'b0;
    end else if (commit) begin
      joy_state <= sh_state;
      md_pad    <= sh_md;
      six_btn   <= sh_six;
    end
  end

endmodule

// File: rtl/sega_joy_scanner.sv
// Multi-port DB9 joystick scanner. Drives the shared select line (pin 7),
// steps through a fixed scan sequence once per frame and publishes per-port
// active-high button words, all ports updating in the same cycle.
//   clk_sys    : system clock
//   reset      : asynchronous, active-high
//   joy_pins_n : per port p at [6p+5:6p] = {p9,p6,right,left,down,up}, active-low
//   joy_p7_o   : shared select line to all ports
//   joy_state  : per port p at [12p+11:12p] = {M,X,Y,Z,S,A,C,B,R,L,D,U}
//   md_pad     : per port, Mega Drive pad detected in last frame
//   six_btn    : per port, 6-button pad detected in last frame
//   frame_done : one-cycle pulse in the cycle the outputs update
module sega_joy_scanner
  import sega_joy_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int TICK_DIV    = 256,
  parameter int FRAME_STEPS = 256,
  parameter bit SIX_BTN_EN  = 1'b1
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [PIN_W*NUM_PORTS-1:0] joy_pins_n,
  output logic                       joy_p7_o,
  output logic [JOY_W*NUM_PORTS-1:0] joy_state,
  output logic [NUM_PORTS-1:0]       md_pad,
  output logic [NUM_PORTS-1:0]       six_btn,
  output logic                       frame_done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int STEP_W = $clog2(FRAME_STEPS);

  logic [PIN_W*NUM_PORTS-1:0] pins_meta;
  logic [PIN_W*NUM_PORTS-1:0] pins_sync;
  logic [TICK_W-1:0]          tick_cnt;
  logic [STEP_W-1:0]          step;
  logic [STEP_W-1:0]          step_nxt;
  logic                       tick;
  logic                       commit;

  // Pins are asynchronous to clk_sys. The synchroniser resets to the idle
  // (pulled-high) level so an empty port reads as nothing pressed.
  // NOTE: sequential state is written with <= only; blocking assignments in
  // clocked blocks create read-order races between processes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pins_meta <= '1;
      pins_sync <= '1;
    end else begin
      pins_meta <= joy_pins_n;
      pins_sync <= pins_meta;
    end
  end

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // NOTE: every signal written in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    step_nxt = step + STEP_W'(1);
    if (step == STEP_W'(FRAME_STEPS - 1)) begin
      step_nxt = '0;
    end
  end

  // Actions belong to the step being entered, so ports see step_nxt.
  assign commit = tick && (step_nxt == STEP_W'(STEP_COMMIT));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      step       <= '0;
      joy_p7_o   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
      if (tick) begin
        step     <= step_nxt;
        joy_p7_o <= p7_level(int'(step_nxt));
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sega_joy_port #(
      .STEP_W     (STEP_W),
      .SIX_BTN_EN (SIX_BTN_EN)
    ) u_port (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .step      (step_nxt),
      .tick      (tick),
      .pins      (pins_sync[PIN_W*p +: PIN_W]),
      .commit    (commit),
      .joy_state (joy_state[JOY_W*p +: JOY_W]),
      .md_pad    (md_pad[p]),
      .six_btn   (six_btn[p])
    );
  end

endmodule

// File: tb/tb_sega_joy_scanner.sv
// Directed bench for sega_joy_scanner with TICK_DIV=4, FRAME_STEPS=16,
// NUM_PORTS=2. Behavioural pad models (none / Master System / 3-button /
// 6-button) answer the select line; a second instance with the 6-button
// phase disabled shares the same pins.
module tb_sega_joy_scanner;

  localparam int NP = 2;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic [11:0]   joy_pins_n;
  logic          joy_p7_o;
  logic [23:0]   joy_state;
  logic [1:0]    md_pad;
  logic [1:0]    six_btn;
  logic          frame_done;
  logic          p7_n6;
  logic [23:0]   joy_state_n6;
  logic [1:0]    md_pad_n6;
  logic [1:0]    six_btn_n6;
  logic          frame_done_n6;

  int            n_checks = 0;
  int            n_errors = 0;

  // Pad models: type 0 = unplugged, 1 = Master System, 2 = MD 3-button,
  // 3 = MD 6-button. Buttons use the DUT word layout, 1 = pressed.
  int            pad_type [NP];
  logic [11:0]   btn      [NP];
  int            lo_cnt = 0;
  int            hi_run = 0;

  always #5 clk_sys = ~clk_sys;

  sega_joy_scanner #(
    .NUM_PORTS   (2),
    .TICK_DIV    (4),
    .FRAME_STEPS (16),
    .SIX_BTN_EN  (1'b1)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy_pins_n (joy_pins_n),
    .joy_p7_o   (joy_p7_o),
    .joy_state  (joy_state),
    .md_pad     (md_pad),
    .six_btn    (six_btn),
    .frame_done (frame_done)
  );

  sega_joy_scanner #(
    .NUM_PORTS   (2),
    .TICK_DIV    (4),
    .FRAME_STEPS (16),
    .SIX_BTN_EN  (1'b0)
  ) dut_n6 (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy_pins_n (joy_pins_n),
    .joy_p7_o   (p7_n6),
    .joy_state  (joy_state_n6),
    .md_pad     (md_pad_n6),
    .six_btn    (six_btn_n6),
    .frame_done (frame_done_n6)
  );

  // Count select low pulses like a 6-button pad; a long high resets it.
  always @(posedge clk_sys) begin
    if (joy_p7_o) begin
      hi_run <= hi_run + 1;
      if (hi_run >= 12) lo_cnt <= 0;
    end else begin
      if (hi_run != 0) lo_cnt <= lo_cnt + 1;
      hi_run <= 0;
    end
  end

  // Returns active-low {p9,p6,right,left,down,up}.
  function automatic logic [5:0] pad_pins(input int typ, input logic [11:0] b,
                                          input logic p7, input int lo);
    logic [5:0] act;
    act = 6'b0;
    case (typ)
      1: act = b[5:0];
      2, 3: begin
        if (p7) begin
          if (typ == 3 && lo == 3) act = {b[5], b[4], b[11], b[10], b[9], b[8]};
          else                     act = b[5:0];
        end else begin
          if (typ == 3 && lo == 3)      act = {b[7], b[6], 4'b1111};
          else if (typ == 3 && lo == 4) act = {b[7], b[6], 4'b0000};
          else                          act = {b[7], b[6], 2'b11, b[1], b[0]};
        end
      end
      default: act = 6'b0;
    endcase
    return ~act;
  endfunction

  assign joy_pins_n[5:0]  = pad_pins(pad_type[0], btn[0], joy_p7_o, lo_cnt);
  assign joy_pins_n[11:6] = pad_pins(pad_type[1], btn[1], joy_p7_o, lo_cnt);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the next frame_done, bounded; n returns cycles waited.
  task automatic wait_fd(input string tag, input int limit, output int n);
    logic seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < limit) begin
      @(posedge clk_sys);
      #1;
      n++;
      seen = frame_done;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int leak;
    int fd_cnt;
    int bad;
    logic [23:0] prev;
    logic [11:0] mid;

    pad_type[0] = 0; pad_type[1] = 0;
    btn[0] = '0;     btn[1] = '0;

    // Reset values.
    repeat (3) @(negedge clk_sys);
    check("rst_p7", 32'(joy_p7_o), 32'd1);
    check("rst_state", 32'(joy_state), 32'h0);
    check("rst_md", 32'(md_pad), 32'h0);
    check("rst_six", 32'(six_btn), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);

    // First commit is on entry to step 8: 8 steps of 4 cycles.
    @(negedge clk_sys) reset = 1'b0;
    wait_fd("first_fd", 200, n);
    check("first_fd_latency", n, 32'd32);
    check("empty_state", 32'(joy_state), 32'h0);
    check("empty_md", 32'(md_pad), 32'h0);
    check("empty_six", 32'(six_btn), 32'h0);
    wait_fd("period", 200, n);
    check("frame_period", n, 32'd64);

    // Port0 Master System (up + B), port1 3-button with Start.
    pad_type[0] = 1; btn[0] = 12'h011;
    pad_type[1] = 2; btn[1] = 12'h080;
    wait_fd("sms_a", 200, n);
    wait_fd("sms_b", 200, n);
    check("sms_md3_state", 32'(joy_state), 32'h080011);
    check("sms_md3_md", 32'(md_pad), 32'h2);
    check("sms_md3_six", 32'(six_btn), 32'h0);

    // Port0 6-button with X and A.
    pad_type[0] = 3; btn[0] = 12'h440;
    wait_fd("md6_a", 200, n);
    wait_fd("md6_b", 200, n);
    check("md6_state", 32'(joy_state), 32'h080440);
    check("md6_md", 32'(md_pad), 32'h3);
    check("md6_six", 32'(six_btn), 32'h1);
    check("md6_off_state", 32'(joy_state_n6), 32'h080040);
    check("md6_off_md", 32'(md_pad_n6), 32'h3);
    check("md6_off_six", 32'(six_btn_n6), 32'h0);

    // Back to Master System on port0.
    pad_type[0] = 1; btn[0] = 12'h011;
    wait_fd("sms2_a", 200, n);
    wait_fd("sms2_b", 200, n);
    check("sms2_state", 32'(joy_state), 32'h080011);

    // Reset while in step 6 (entered 56 cycles after a commit).
    repeat (58) @(posedge clk_sys);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(joy_state), 32'h0);
    check("midrst_md", 32'(md_pad), 32'h0);
    check("midrst_p7", 32'(joy_p7_o), 32'd1);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    leak = 0;
    n    = 0;
    while (!frame_done && n < 200) begin
      @(posedge clk_sys);
      #1;
      n++;
      if (!frame_done && (joy_state != '0 || md_pad != '0 || six_btn != '0)) leak++;
    end
    check("midrst_fd_seen", 32'(frame_done), 32'd1);
    check("midrst_latency", n, 32'd32);
    check("midrst_leak", leak, 32'd0);
    check("midrst_commit_state", 32'(joy_state), 32'h080011);
    check("midrst_commit_md", 32'(md_pad), 32'h2);

    // Change buttons mid-frame; outputs may move only in frame_done cycles.
    fd_cnt = 0;
    bad    = 0;
    mid    = '0;
    prev   = joy_state;
    for (int i = 1; i <= 192; i++) begin
      @(posedge clk_sys);
      #1;
      if (i == 44) btn[0] = 12'h022;
      if (frame_done) fd_cnt++;
      else if (joy_state != prev) bad++;
      if (i == 64) mid = joy_state[11:0];
      prev = joy_state;
    end
    check("toggle_fd_count", fd_cnt, 32'd3);
    check("toggle_no_partial", bad, 32'd0);
    check("toggle_mid_frame", 32'(mid), 32'h011);
    check("toggle_next_frame", 32'(joy_state[11:0]), 32'h022);

    // Hot unplug port1.
    pad_type[1] = 0; btn[1] = '0;
    wait_fd("unplug_a", 200, n);
    wait_fd("unplug_b", 200, n);
    check("unplug_state", 32'(joy_state), 32'h000022);
    check("unplug_md", 32'(md_pad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
